// File: rtl/restoring_div16.sv
// Sequential restoring divider: byte-serial operand load, one quotient bit per
// CALC cycle, divide-by-zero short-circuit straight to DONE.
module restoring_div16 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         getN,
  input  logic         getD,
  input  logic [7:0]   in,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         ready,
  output logic         dz
);

  typedef enum logic [2:0] {
    IDLE, LD_N0, LD_N1, LD_D0, LD_D1, CALC, DONE
  } state_t;

  state_t         state, state_nx;
  logic           getn_prev, getd_prev;
  logic           getn_edge, getd_edge;
  logic [W-1:0]   n_reg, d_reg, q_reg, r_reg;
  logic [W-1:0]   d_full;
  logic [3:0]     cnt;
  logic           dz_reg;
  logic           accept_start;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep
  // the difference only when it did not go negative.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r,
                                              input logic [W-1:0] q,
                                              input logic [W-1:0] d);
    logic [W-1:0]        shifted;
    logic signed [W:0]   t;
    shifted = {r[W-2:0], q[W-1]};
    t = $signed({1'b0, shifted}) - $signed({1'b0, d});
    if (!t[W])
      div_step = {t[W-1:0], q[W-2:0], 1'b1};
    else
      div_step = {shifted, q[W-2:0], 1'b0};
  endfunction

  assign getn_edge    = getN & ~getn_prev;
  assign getd_edge    = getD & ~getd_prev;
  assign d_full       = {in, d_reg[7:0]};
  assign accept_start = ((state == IDLE) || (state == DONE)) && start;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = LD_N0;
      LD_N0:      if (getn_edge) state_nx = LD_N1;
      LD_N1:      if (getn_edge) state_nx = LD_D0;
      LD_D0:      if (getd_edge) state_nx = LD_D1;
      LD_D1:      if (getd_edge) state_nx = (d_full == '0) ? DONE : CALC;
      CALC:       if (cnt == 4'd15) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      getn_prev <= 1'b0;
      getd_prev <= 1'b0;
    end else begin
      state     <= state_nx;
      getn_prev <= getN;
      getd_prev <= getD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      n_reg  <= '0;
      d_reg  <= '0;
      q_reg  <= '0;
      r_reg  <= '0;
      cnt    <= '0;
      dz_reg <= 1'b0;
    end else if (accept_start) begin
      n_reg  <= '0;
      d_reg  <= '0;
      q_reg  <= '0;
      r_reg  <= '0;
      dz_reg <= 1'b0;
    end else begin
      case (state)
        LD_N0: if (getn_edge) n_reg[7:0]   <= in;
        LD_N1: if (getn_edge) n_reg[W-1:8] <= in;
        LD_D0: if (getd_edge) d_reg[7:0]   <= in;
        LD_D1: begin
          if (getd_edge) begin
            d_reg[W-1:8] <= in;
            // A zero divisor bypasses CALC with the saturated quotient.
            if (d_full == '0) begin
              q_reg  <= '1;
              r_reg  <= n_reg;
              dz_reg <= 1'b1;
            end else begin
              q_reg <= n_reg;
              r_reg <= '0;
              cnt   <= '0;
            end
          end
        end
        CALC: begin
          {r_reg, q_reg} <= div_step(r_reg, q_reg, d_reg);
          cnt            <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign quotient  = q_reg;
  assign remainder = r_reg;
  assign busy      = (state == CALC);
  assign ready     = (state == DONE);
  assign dz        = dz_reg;

endmodule

// File: tb/tb_restoring_div16.sv
// Bench for restoring_div16: table vectors, randomized operands against an
// arithmetic reference, and hand sequences for strobe, reset and restart cases.
module tb_restoring_div16;

  logic        clk = 1'b0;
  logic        rst, start, getN, getD;
  logic [7:0]  in;
  logic [15:0] quotient, remainder;
  logic        busy, ready, dz;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] n, d, q, r;
    logic        z;
  } vec_t;

  vec_t vecs[8];

  restoring_div16 #(.W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .getN(getN), .getD(getD), .in(in),
    .quotient(quotient), .remainder(remainder), .busy(busy), .ready(ready), .dz(dz)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, saturated quotient on a zero divisor.
  task automatic model(input logic [15:0] n, input logic [15:0] d,
                       output logic [15:0] q, output logic [15:0] r, output logic z);
    if (d == 16'd0) begin
      q = 16'hFFFF; r = n; z = 1'b1;
    end else begin
      q = n / d; r = n % d; z = 1'b0;
    end
  endtask

  task automatic strobe(input bit use_d, input logic [7:0] b);
    @(negedge clk);
    in = b;
    if (use_d) getD = 1'b1; else getN = 1'b1;
    @(negedge clk);
    getN = 1'b0;
    getD = 1'b0;
  endtask

  task automatic accept_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " ready_cleared"}, ready, 0);
    check({tag, " dz_cleared"}, dz, 0);
    check({tag, " q_cleared"}, quotient, 0);
  endtask

  task automatic finish_op(input logic [15:0] d, input logic [15:0] eq,
                           input logic [15:0] er, input logic ez,
                           input bit noise, input string tag);
    int cyc;
    int busy_cycles;
    strobe(1'b1, d[7:0]);
    @(negedge clk);
    in = d[15:8];
    getD = 1'b1;
    cyc = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cycles++;
      start = 1'b0; getN = 1'b0; getD = 1'b0;
      if (noise && cyc < 12) begin
        start = 1'($urandom_range(0, 1));
        getN  = 1'($urandom_range(0, 1));
        getD  = 1'($urandom_range(0, 1));
        in    = 8'($urandom);
      end
    end while (!ready && cyc < 40);
    start = 1'b0; getN = 1'b0; getD = 1'b0;
    check({tag, " latency"}, cyc, ez ? 1 : 17);
    check({tag, " busy_cycles"}, busy_cycles, ez ? 0 : 16);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " dz"}, dz, ez);
    repeat (2) @(negedge clk);
    check({tag, " hold_ready"}, ready, 1);
    check({tag, " hold_q"}, quotient, eq);
  endtask

  task automatic run_op(input logic [15:0] n, input logic [15:0] d,
                        input logic [15:0] eq, input logic [15:0] er, input logic ez,
                        input bit noise, input string tag);
    accept_start(tag);
    strobe(1'b0, n[7:0]);
    strobe(1'b0, n[15:8]);
    finish_op(d, eq, er, ez, noise, tag);
  endtask

  initial begin
    logic [15:0] rn, rd, eq, er;
    logic        ez;

    vecs[0] = '{n:16'h03E8, d:16'h0007, q:16'h008E, r:16'h0006, z:1'b0};
    vecs[1] = '{n:16'hFFFF, d:16'h0001, q:16'hFFFF, r:16'h0000, z:1'b0};
    vecs[2] = '{n:16'h0003, d:16'h000A, q:16'h0000, r:16'h0003, z:1'b0};
    vecs[3] = '{n:16'h0005, d:16'h0000, q:16'hFFFF, r:16'h0005, z:1'b1};
    vecs[4] = '{n:16'hFFFF, d:16'hFFFF, q:16'h0001, r:16'h0000, z:1'b0};
    vecs[5] = '{n:16'h8000, d:16'h0003, q:16'h2AAA, r:16'h0002, z:1'b0};
    vecs[6] = '{n:16'h1234, d:16'h0100, q:16'h0012, r:16'h0034, z:1'b0};
    vecs[7] = '{n:16'h0000, d:16'h0000, q:16'hFFFF, r:16'h0000, z:1'b1};

    rst = 1'b0; start = 1'b0; getN = 1'b0; getD = 1'b0; in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset busy", busy, 0);
    check("reset ready", ready, 0);
    check("reset dz", dz, 0);
    rst = 1'b1;

    // Back-to-back table vectors also exercise restart from DONE.
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r, vecs[i].z, 1'b0,
             $sformatf("vec%0d", i));

    for (int i = 0; i < 25; i++) begin
      rn = 16'($urandom);
      case (i % 4)
        0:       rd = 16'($urandom_range(0, 3));
        1:       rd = 16'($urandom_range(1, 255));
        default: rd = 16'($urandom);
      endcase
      model(rn, rd, eq, er, ez);
      run_op(rn, rd, eq, er, ez, (rd != 0) && (i % 3 == 0), $sformatf("rnd%0d", i));
    end

    // Held getN plus stray getD and start during loading.
    accept_start("held");
    @(negedge clk);
    in = 8'h34; getN = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in = 8'hA5;
      getD  = (k == 3);
      start = (k == 6);
    end
    @(negedge clk);
    getN = 1'b0; getD = 1'b0; start = 1'b0;
    strobe(1'b0, 8'h12);
    finish_op(16'h0010, 16'h0123, 16'h0004, 1'b0, 1'b0, "held");

    // Reset on the 8th CALC cycle.
    accept_start("rstcalc");
    strobe(1'b0, 8'hE8);
    strobe(1'b0, 8'h03);
    strobe(1'b1, 8'h07);
    @(negedge clk);
    in = 8'h00; getD = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      getD = 1'b0;
    end
    check("rstcalc busy_before", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rstcalc busy", busy, 0);
    check("rstcalc ready", ready, 0);
    check("rstcalc quotient", quotient, 0);
    check("rstcalc remainder", remainder, 0);
    strobe(1'b0, 8'h11);
    strobe(1'b0, 8'h22);
    strobe(1'b1, 8'h01);
    strobe(1'b1, 8'h00);
    repeat (20) @(negedge clk);
    check("rstcalc no_restart_ready", ready, 0);
    check("rstcalc no_restart_busy", busy, 0);
    run_op(16'h03E8, 16'h0007, 16'h008E, 16'h0006, 1'b0, 1'b0, "recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/restoring_div16.md
RESTORING_DIV16 -- requirements
Module: restoring_div16

Interface
REQ-001 SHALL have parameter W, default 16, meaning dividend, divisor, quotient and remainder width; only W=16 is required to be supported.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  level request to begin a new load/divide sequence.
REQ-005 SHALL have port getN  input  1  dividend byte strobe; rising edge captures in.
REQ-006 SHALL have port getD  input  1  divisor byte strobe; rising edge captures in.
REQ-007 SHALL have port in  input  8  operand byte bus.
REQ-008 SHALL have port quotient  output  16  unsigned quotient.
REQ-009 SHALL have port remainder  output  16  unsigned remainder.
REQ-010 SHALL have port busy  output  1  high in CALC.
REQ-011 SHALL have port ready  output  1  high in DONE; results valid.
REQ-012 SHALL have port dz  output  1  divide-by-zero flag, valid while ready is high.

Function
REQ-013 SHALL implement states IDLE, LD_N0, LD_N1, LD_D0, LD_D1, CALC, DONE.
REQ-014 SHALL detect strobe rising edges synchronously: strobe high this cycle, low the previous cycle. A strobe held high for many cycles SHALL capture exactly one byte.
REQ-015 SHALL transition IDLE->LD_N0 and DONE->LD_N0 on start=1; on that transition it SHALL clear ready and dz and zero the N, D, quotient and remainder registers.
REQ-016 SHALL, in LD_N0, capture in into N[7:0] on a getN edge and go to LD_N1.
REQ-017 SHALL, in LD_N1, capture in into N[15:8] on a getN edge and go to LD_D0.
REQ-018 SHALL, in LD_D0, capture in into D[7:0] on a getD edge and go to LD_D1.
REQ-019 SHALL, in LD_D1, capture in into D[15:8] on a getD edge and then go to CALC, or to DONE if the complete D is zero.
REQ-020 SHALL ignore strobes that do not match the current load state (e.g. getD in LD_N0); in load states it SHALL also ignore start.
REQ-021 SHALL, on entry to CALC, set a 16-bit partial remainder R=0, set Q=N, and set a 4-bit iteration counter to 0.
REQ-022 SHALL, each CALC cycle, form T = {R[14:0],Q[15]} - D using a 17-bit subtract.
 - If T is non-negative: R<=T[15:0] and Q<={Q[14:0],1}.
 - Otherwise: R<={R[14:0],Q[15]} and Q<={Q[14:0],0}.
REQ-023 SHALL spend exactly 16 cycles in CALC. On the 16th cycle (counter=15) it SHALL go to DONE, and the counter SHALL wrap to 0.
REQ-024 SHALL drive quotient=Q and remainder=R continuously, and hold them stable in DONE until the next accepted start.
REQ-025 SHALL, for D=0, skip CALC and enter DONE with quotient=16'hFFFF, remainder=N and dz=1, one cycle after the final getD edge.
REQ-026 SHALL assert ready on the clock edge that enters DONE; the latency from the final getD capture edge to ready high SHALL be 17 cycles for D≠0.
REQ-027 SHALL ignore start, getN and getD during CALC.
REQ-028 SHALL produce results satisfying N = quotient*D + remainder with remainder < D, for all N and all D≠0.

Reset
REQ-029 SHALL, when rst=0 at a clock edge, enter IDLE and set the following to 0: N, D, Q, R, the counter, the edge-detect history, busy, ready and dz. This SHALL apply in any state.
REQ-030 SHALL, when rst=0 mid-CALC or mid-load, abandon the operation with no partial results retained; after rst=1 it SHALL require a new start.
REQ-031 SHALL initialize the edge-detect history to 0 on reset, so a strobe already high when rst releases counts as a rising edge.

Verification
REQ-032 SHALL be verified by: start; bytes N=0x03E8 and D=0x0007 -> after 17 cycles ready=1, quotient=0x008E, remainder=0x0006, dz=0.
REQ-033 SHALL be verified by: N=0xFFFF, D=0x0001 -> quotient=0xFFFF, remainder=0x0000; and N=0x0003, D=0x000A -> quotient=0x0000, remainder=0x0003.
REQ-034 SHALL be verified by: N=0x0005, D=0x0000 -> one cycle after the last getD, ready=1, dz=1, quotient=0xFFFF, remainder=0x0005, busy never high.
REQ-035 SHALL be verified by: getN held high for 10 cycles in LD_N0, plus getD pulsed in LD_N0 -> only N[7:0] is captured, state is LD_N1, D is unchanged.
REQ-036 SHALL be verified by: rst=0 on the 8th CALC cycle -> next cycle state is IDLE, busy=0, ready=0, quotient=0, remainder=0.
REQ-037 SHALL be verified by: a second start from DONE followed by new operands -> ready drops on acceptance, and new correct results appear after 17 cycles.
